sap_clken_gen: RTL
==================

# sap_clken_gen

Parametrised clock-enable generator for the SAP CPU core. It replaces fixed divide-by-CLKLEN enable logic with a programmable divider and adds run, single-step and stop modes, halt handling and a pulse counter. It drives the `clken` / `clken_oop` strobes consumed by `sap1`, and sits between the front panel and the CPU in the top level, entirely in the `sysclk` domain.

## Interface
Parameters:
- `DIV_WIDTH`, 8: width of the half-period divide input.
- `CNT_WIDTH`, 16: width of the clken pulse counter.

Ports:
- `sysclk`: in, 1. System clock; every register is clocked on its rising edge.
- `reset_n`: in, 1. Asynchronous, active-low reset.
- `div`: in, DIV_WIDTH. Half-period length in sysclk cycles; 0 is treated as 1.
- `mode`: in, 2. 00 stop, 01 run, 10 single-step, 11 reserved (behaves as stop).
- `step_req`: in, 1. Front-panel step level, synchronous to sysclk; its rising edge requests one period.
- `halt`: in, 1. CPU halt level.
- `clk_out`: out, 1. Visible CPU phase clock (for LED/debug); high during the HI state.
- `clken`: out, 1. One-sysclk strobe at each rising edge of the CPU phase clock.
- `clken_oop`: out, 1. One-sysclk strobe at each falling edge of the CPU phase clock.
- `busy`: out, 1. High whenever the state is not IDLE.
- `pulse_count`: out, CNT_WIDTH. Number of clken strobes issued since reset.

## Operation
- FSM states: IDLE, LO, HI. The state register and a DIV_WIDTH-bit counter `cnt` are both registered.
- `div_eff` = (div==0) ? 1 : div. It is latched into `div_q` on every entry to LO, so a `div` change during a period takes effect at the next period.
- Start condition, evaluated only in IDLE:
  - (mode==01 && !halt), or
  - (mode==10 && !halt && rising edge of step_req).
- IDLE → LO when the start condition holds; cnt cleared to 0.
- LO: cnt increments each cycle.
  - At cnt==div_q-1: → HI, cnt=0, and clken=1 for the next cycle.
- HI: cnt increments each cycle.
  - At cnt==div_q-1: clken_oop=1 for the next cycle, cnt=0.
  - Then → LO if (mode==01 && !halt), which relatches div.
  - Otherwise → IDLE.
- A started period always completes both halves. halt, mode changes and step edges have no effect until the HI terminal cycle.
- Single-step: each accepted step edge yields exactly one clken and one clken_oop, then IDLE.
  - Step edges arriving while busy, or while halt=1, or when mode≠10, are discarded (not queued).
- Step edge detector: `step_prev` register; edge = step_req && !step_prev.
  - step_prev resets to 1, so a button already held at reset release produces no step.
- pulse_count increments on every cycle that clken=1 and wraps from all-ones to 0.
- clk_out = (state==HI), driven from a register.

## Timing
- Reset (asynchronous, reset_n=0):
  - state=IDLE, cnt=0, div_q=1, step_prev=1.
  - clk_out=0, clken=0, clken_oop=0, busy=0, pulse_count=0.
- Reset asserted mid-period aborts immediately; no pulse is emitted during or after reset.
- Latency: let E0 be the sysclk edge that samples the start condition true.
  - LO from E0.
  - clken high for the single cycle after edge E0+div_q; clk_out rises at the same edge.
  - clken_oop high for the cycle after edge E0+2·div_q; clk_out falls at the same edge.
- Continuous run: period 2·div_q cycles; clken and clken_oop are spaced div_q cycles apart, never both high together.
- div_eff=1: clk_out toggles every cycle; clken and clken_oop alternate every cycle.
- Run → IDLE (halt, or mode change): the last output is clken_oop; busy drops with the transition to IDLE, i.e. in the same cycle clken_oop is high.
- Halt deasserted while in IDLE with mode==01: restart follows the normal latency rule from the sampling edge.

## Test plan
- Reset, then mode=01, div=4, halt=0:
  - first clken after 4 cycles, clken_oop 4 cycles later, period 8;
  - pulse_count=10 after 10 periods.
- Run with div=3, change div to 6 mid-LO: current period stays 3+3; the next period is 6+6. div=0 behaves exactly as div=1, alternating strobes every cycle.
- Run, assert halt midway through LO: LO and HI complete (one clken, one clken_oop), then IDLE with busy=0 and clk_out=0. Deassert halt: restart after the normal latency.
- mode=10, div=2:
  - one step_req pulse → exactly one clken and one clken_oop, then IDLE;
  - a second step edge while busy is ignored;
  - step_req held high through reset release → no pulse.
- Assert reset_n=0 during HI: all outputs 0 immediately, pulse_count=0; after release with mode=00, no strobes appear.
- Force pulse_count to all-ones via CNT_WIDTH=4 and 16 pulses: the count wraps to 0.

Source files
------------

// File: rtl/sap_clken_gen.sv
// Programmable clock-enable generator for the SAP CPU: run, single-step and stop
// modes with halt handling, producing clken/clken_oop strobes and a pulse counter.
module sap_clken_gen #(
   parameter int unsigned DIV_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 sysclk,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [1:0]           mode,
   input  logic                 step_req,
   input  logic                 halt,
   output logic                 clk_out,
   output logic                 clken,
   output logic                 clken_oop,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pulse_count
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LO   = 2'b01,
      HI   = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 step_prev_q, step_prev_d;
   logic                 clk_out_q, clk_out_d;
   logic                 clken_q, clken_d;
   logic                 clken_oop_q, clken_oop_d;
   logic                 busy_q, busy_d;
   logic [CNT_WIDTH-1:0] pulse_count_q, pulse_count_d;

   logic [DIV_WIDTH-1:0] div_eff;
   logic                 run_ok;
   logic                 step_edge;
   logic                 start;
   logic                 terminal;

   always_comb begin
      div_eff       = (div == '0) ? DIV_WIDTH'(1) : div;
      run_ok        = (mode == 2'b01) && !halt;
      step_edge     = step_req && !step_prev_q;
      start         = run_ok || ((mode == 2'b10) && !halt && step_edge);
      terminal      = (cnt_q == (div_q - DIV_WIDTH'(1)));

      state_d       = state_q;
      cnt_d         = cnt_q + DIV_WIDTH'(1);
      div_d         = div_q;
      clken_d       = 1'b0;
      clken_oop_d   = 1'b0;
      step_prev_d   = step_req;
      pulse_count_d = pulse_count_q + CNT_WIDTH'(clken_q);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = LO;
               div_d   = div_eff;
            end
         end
         LO: begin
            if (terminal) begin
               state_d = HI;
               cnt_d   = '0;
               clken_d = 1'b1;
            end
         end
         HI: begin
            // Mode/halt are only looked at here, so a started period always completes.
            if (terminal) begin
               clken_oop_d = 1'b1;
               cnt_d       = '0;
               if (run_ok) begin
                  state_d = LO;
                  div_d   = div_eff;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      clk_out_d = (state_d == HI);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         div_q         <= DIV_WIDTH'(1);
         step_prev_q   <= 1'b1;
         clk_out_q     <= 1'b0;
         clken_q       <= 1'b0;
         clken_oop_q   <= 1'b0;
         busy_q        <= 1'b0;
         pulse_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_q         <= div_d;
         step_prev_q   <= step_prev_d;
         clk_out_q     <= clk_out_d;
         clken_q       <= clken_d;
         clken_oop_q   <= clken_oop_d;
         busy_q        <= busy_d;
         pulse_count_q <= pulse_count_d;
      end
   end

   assign clk_out     = clk_out_q;
   assign clken       = clken_q;
   assign clken_oop   = clken_oop_q;
   assign busy        = busy_q;
   assign pulse_count = pulse_count_q;

endmodule
